cordic_mult_seq: RTL

- Parametrised sequential linear-mode CORDIC multiplier, next generation of the fixed 8-bit/16-iteration multiplier.
- Computes y = x * z, with signed integer x and signed fractional z in Q1.(DATA_W-1), one shift-add iteration per cycle.
- Adds a valid/ready handshake on input and output, configurable width and iteration count, and an optional approximate accumulator adder for accuracy/energy exploration.
- Sits between operand-staging logic and the result collector in the approximate-arithmetic datapath.

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_lin_adder.sv | 21 ++
 rtl/cordic_mult_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and elaboration helpers for the sequential linear-mode CORDIC multiplier.
package cordic_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int calc_yw(input int data_w, input int iter);
        return data_w + iter;
    endfunction

    function automatic bit params_ok(input int data_w, input int iter, input int approx_lsb);
        return (data_w >= 4) && (data_w <= 16) && (iter >= 2) && (iter <= data_w) &&
               (approx_lsb >= 0) && (approx_lsb < data_w + iter);
    endfunction

    function automatic int cnt_w(input int iter);
        return $clog2(iter + 1);
    endfunction

endpackage

// File: rtl/cordic_lin_adder.sv
// YW-bit accumulator adder: exact when LOA_W is 0, otherwise a lower-part-OR adder
// whose low LOA_W bits are a|b with no carry into the exact upper part.
module cordic_lin_adder #(
    parameter int YW    = 16,
    parameter int LOA_W = 0
) (
    input  logic [YW-1:0] a,
    input  logic [YW-1:0] b,
    output logic [YW-1:0] sum
);

    generate
        if (LOA_W == 0) begin : g_exact
            assign sum = a + b;
        end else begin : g_loa
            assign sum[LOA_W-1:0]  = a[LOA_W-1:0] | b[LOA_W-1:0];
            assign sum[YW-1:LOA_W] = a[YW-1:LOA_W] + b[YW-1:LOA_W];
        end
    endgenerate

endmodule

// File: rtl/cordic_mult_seq.sv
// Sequential linear-mode CORDIC multiplier y = x * z with valid/ready handshakes.
// Define APPROX_ADD_EN to build the accumulator with a lower-part-OR approximate adder.
module cordic_mult_seq
    import cordic_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int ITER       = 8,
    parameter  int APPROX_LSB = 4,
    localparam int YW         = calc_yw(DATA_W, ITER)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] z_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [YW-1:0]     y_o,
    output logic              busy
);

    localparam int CW = cnt_w(ITER);
    localparam int ZW = DATA_W + 1;
`ifdef APPROX_ADD_EN
    localparam int LOA_W = APPROX_LSB;
`else
    localparam int LOA_W = 0;
`endif

    generate
        if (!params_ok(DATA_W, ITER, APPROX_LSB)) begin : g_bad_params
            $error("cordic_mult_seq: DATA_W/ITER/APPROX_LSB out of legal range");
        end
    endgenerate

    state_t         state_reg;
    logic [CW-1:0]  cnt_reg;
    logic [YW-1:0]  y_reg;
    logic [YW-1:0]  x_reg;
    logic [ZW-1:0]  z_reg;

    logic              d_pos;
    logic signed [YW-1:0] x_shift;
    logic [YW-1:0]     y_operand;
    logic [YW-1:0]     y_next;
    logic [ZW-1:0]     z_unit;
    logic [ZW-1:0]     z_step;
    logic [ZW-1:0]     z_next;
    logic [YW-1:0]     x_load;
    logic [ZW-1:0]     z_load;
    logic              last_iter;

    // X carries ITER-1 fractional bits so every arithmetic right shift is exact.
    assign x_load    = {x_i[DATA_W-1], x_i, {(ITER-1){1'b0}}};
    assign z_load    = {z_i[DATA_W-1], z_i};
    assign d_pos     = ~z_reg[ZW-1];
    assign x_shift   = $signed(x_reg) >>> cnt_reg;
    assign y_operand = d_pos ? x_shift : (~x_shift + YW'(1));
    assign z_unit    = {2'b01, {(DATA_W-1){1'b0}}};
    assign z_step    = z_unit >> cnt_reg;
    assign z_next    = d_pos ? (z_reg - z_step) : (z_reg + z_step);
    assign last_iter = (cnt_reg == CW'(ITER - 1));

    cordic_lin_adder #(
        .YW    (YW),
        .LOA_W (LOA_W)
    ) u_adder (
        .a   (y_reg),
        .b   (y_operand),
        .sum (y_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            y_reg     <= '0;
            x_reg     <= '0;
            z_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_reg     <= x_load;
                        z_reg     <= z_load;
                        y_reg     <= '0;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    y_reg   <= y_next;
                    z_reg   <= z_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_iter) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign y_o       = y_reg;

endmodule
